// File: rtl/bg_chain_if.sv
// Grant-chain bundle: bus-side grant pins, per-device grant pairs, slot-map config port, status.
interface bg_chain_if #(
  parameter int NDEV = 7,
  parameter int DW   = 4
);
  logic            grant_in;
  logic            grant_out;
  logic [NDEV:1]   dev_gi;
  logic [NDEV:1]   dev_go;
  logic            cfg_wr;
  logic [DW-1:0]   cfg_slot;
  logic [DW-1:0]   cfg_dev;
  logic            cfg_clr;
  logic            cfg_busy;
  logic            cfg_err;
  logic [DW-1:0]   grant_slot;
  logic            stuck;

  modport slave (
    input  grant_in, dev_go, cfg_wr, cfg_slot, cfg_dev, cfg_clr,
    output grant_out, dev_gi, cfg_busy, cfg_err, grant_slot, stuck
  );

  modport master (
    output grant_in, dev_go, cfg_wr, cfg_slot, cfg_dev, cfg_clr,
    input  grant_out, dev_gi, cfg_busy, cfg_err, grant_slot, stuck
  );
endinterface

// File: rtl/bg_chain.sv
// Registered Q-bus grant daisy chain over NSLOT run-time mapped slots, with shadowed map and watchdog.
// Optional BG_SYNC_EN: adds a 2-flop synchroniser on grant_in ahead of the chain and FSM.

// Per-slot device decode: which device sits here and what its grant-out says.
module bg_slot #(
  parameter int NDEV = 7,
  parameter int DW   = 4
) (
  input  logic [DW-1:0] dev,
  input  logic [NDEV:1] dev_go,
  output logic          occ,
  output logic          go,
  output logic [NDEV:1] sel
);
  always_comb begin
    sel = '0;
    go  = 1'b1;
    for (int d = 1; d <= NDEV; d++)
      if (dev == DW'(d)) begin
        sel[d] = 1'b1;
        go     = dev_go[d];
      end
  end

  assign occ = |sel;
endmodule

module bg_chain #(
  parameter int NSLOT   = 5,
  parameter int NDEV    = 7,
  parameter int DW      = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  bg_chain_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, PASS, HELD} state_t;

  typedef struct packed {
    logic [DW-1:0] slot;
    logic [DW-1:0] dev;
  } cfg_req_t;

  logic grant_sync;

`ifdef BG_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], bus.grant_in};
  assign grant_sync = sync_q[1];
`else
  assign grant_sync = bus.grant_in;
`endif

  logic [NSLOT:1][DW-1:0]   slot_map;
  logic [NSLOT:1]           slot_occ;
  logic [NSLOT:1]           slot_go;
  logic [NSLOT:1][NDEV:1]   slot_sel;

  for (genvar k = 1; k <= NSLOT; k++) begin : g_slot
    bg_slot #(.NDEV(NDEV), .DW(DW)) u_slot (
      .dev    (slot_map[k]),
      .dev_go (bus.dev_go),
      .occ    (slot_occ[k]),
      .go     (slot_go[k]),
      .sel    (slot_sel[k])
    );
  end

  // Walk the chain in one process; empty slots pass the grant straight through.
  logic           chain_c;
  logic           chain_out;
  logic [NDEV:1]  chain_gi;
  logic [DW-1:0]  blk_slot;

  always_comb begin
    chain_c  = grant_sync;
    chain_gi = '0;
    blk_slot = '0;
    for (int k = 1; k <= NSLOT; k++) begin
      chain_gi = chain_gi | (slot_sel[k] & {NDEV{chain_c}});
      if (slot_occ[k]) begin
        if (chain_c && !slot_go[k] && blk_slot == '0) blk_slot = DW'(k);
        chain_c = slot_go[k];
      end
    end
    chain_out = chain_c;
  end

  assign bus.grant_out = chain_out;
  assign bus.dev_gi    = chain_gi;

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_sync) state_nxt = chain_out ? PASS : HELD;
      PASS:    if (!grant_sync) state_nxt = IDLE;
               else if (!chain_out) state_nxt = HELD;
      HELD:    if (!grant_sync) state_nxt = IDLE;
               else if (chain_out) state_nxt = PASS;
      default: state_nxt = IDLE;
    endcase
  end

  cfg_req_t pend;
  logic     busy;
  logic     err_q;
  logic     wr_conflict;
  logic     wr_reject;
  logic     commit;

  // A device may live in only one slot, counting the write still waiting to commit.
  always_comb begin
    wr_conflict = 1'b0;
    for (int k = 1; k <= NSLOT; k++)
      if (DW'(k) != bus.cfg_slot && slot_map[k] == bus.cfg_dev) wr_conflict = 1'b1;
    if (busy && pend.dev == bus.cfg_dev && pend.slot != bus.cfg_slot) wr_conflict = 1'b1;
    if (bus.cfg_dev == '0) wr_conflict = 1'b0;
  end

  assign wr_reject = (bus.cfg_slot == '0) || (bus.cfg_slot > DW'(NSLOT)) ||
                     (bus.cfg_dev > DW'(NDEV)) || wr_conflict || busy;
  assign commit    = busy && (state == IDLE) && !grant_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_map <= '0;
      pend     <= '0;
      busy     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= bus.cfg_wr && wr_reject;
      if (commit) begin
        for (int k = 1; k <= NSLOT; k++)
          if (DW'(k) == pend.slot) slot_map[k] <= pend.dev;
        busy <= 1'b0;
      end else if (bus.cfg_wr && !wr_reject) begin
        pend.slot <= bus.cfg_slot;
        pend.dev  <= bus.cfg_dev;
        busy      <= 1'b1;
      end
    end
  end

  logic [DW-1:0] slot_q;
  logic [15:0]   wd_cnt;
  logic [15:0]   wd_inc;
  logic          wd_hit;
  logic          stuck_q;

  assign wd_inc = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;
  assign wd_hit = (wd_inc >= 16'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= '0;
      wd_cnt  <= '0;
      stuck_q <= 1'b0;
    end else begin
      // Capture the blocking slot only on entry; hold it for the life of the HELD episode.
      if (state_nxt == HELD) slot_q <= (state == HELD) ? slot_q : blk_slot;
      else                   slot_q <= '0;
      wd_cnt <= (state == HELD) ? wd_inc : '0;
      if (state == HELD && wd_hit) stuck_q <= 1'b1;
      else if (bus.cfg_clr)        stuck_q <= 1'b0;
    end
  end

  assign bus.cfg_busy   = busy;
  assign bus.cfg_err    = err_q;
  assign bus.grant_slot = slot_q;
  assign bus.stuck      = stuck_q;
endmodule
